// File: rtl/text_scroll_engine_pkg.sv
// Shared types and helpers for the text scroll engine.
// Geometry comes from `CONSOLE_COLUMNS / `CONSOLE_LINES.
`ifndef CONSOLE_COLUMNS
`define CONSOLE_COLUMNS 80
`endif
`ifndef CONSOLE_LINES
`define CONSOLE_LINES 24
`endif

package text_scroll_engine_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COPY_RD,
    S_COPY_WR,
    S_CLEAR,
    S_DONE
  } scroll_state_t;

  typedef struct packed {
    logic       dir;
    logic [7:0] step;
    logic [7:0] top;
    logic [7:0] bottom;
  } scroll_req_t;

  typedef struct packed {
    logic       dir;
    logic [7:0] top;
    logic [7:0] bot;
    logic [7:0] n;
    logic [7:0] h;
  } scroll_job_t;

  // Clip region to the buffer and clamp the step to the region height.
  function automatic scroll_job_t make_job(
    input scroll_req_t r,
    input logic [7:0]  last_row
  );
    scroll_job_t j;
    j.dir = r.dir;
    j.top = r.top;
    j.bot = (r.bottom > last_row) ? last_row : r.bottom;
    j.h   = (r.top > j.bot) ? 8'd0
          : j.bot - r.top + 8'd1;
    j.n   = (r.step < j.h) ? r.step : j.h;
    return j;
  endfunction

endpackage

// File: rtl/text_scroll_engine_queue.sv
// One-deep pending slot for scroll requests (scroll_req_queue).
// SCROLL_MERGE_EN: same-region requests fold into the pending step.
module scroll_req_queue
  import text_scroll_engine_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        push,
  input  scroll_req_t push_req,
  input  logic        pop,
  output logic        pend_valid,
  output scroll_req_t pend_req,
  output logic        overflow
);

  logic       can_merge;
  logic [7:0] merged_step;

`ifdef SCROLL_MERGE_EN
  logic [8:0] step_sum;
  assign step_sum = {1'b0, pend_req.step}
                  + {1'b0, push_req.step};
  assign merged_step = step_sum[8] ? 8'hFF
                     : step_sum[7:0];
  assign can_merge =
    (pend_req.dir == push_req.dir) &&
    (pend_req.top == push_req.top) &&
    (pend_req.bottom == push_req.bottom);
`else
  assign merged_step = pend_req.step;
  assign can_merge   = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_valid <= 1'b0;
      pend_req   <= '0;
      overflow   <= 1'b0;
    end else if (flush) begin
      pend_valid <= 1'b0;
      overflow   <= 1'b0;
    end else if (pop && push) begin
      pend_req   <= push_req;
    end else if (pop) begin
      pend_valid <= 1'b0;
    end else if (push) begin
      if (!pend_valid) begin
        pend_valid <= 1'b1;
        pend_req   <= push_req;
      end else if (can_merge) begin
        pend_req.step <= merged_step;
      end else begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/text_scroll_engine.sv
// Applies scroll requests to the text RAM: row copy, then blank fill.
// Optional SCROLL_MERGE_EN merges same-region pending requests.
module text_scroll_engine
  import text_scroll_engine_pkg::*;
#(
  parameter int COLS   = `CONSOLE_COLUMNS,
  parameter int LINES  = `CONSOLE_LINES,
  parameter int CELL_W = 32,
  parameter int ADDR_W = 12,
  parameter logic [CELL_W-1:0] BLANK_CELL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scroll_valid,
  input  logic              scroll_dir,
  input  logic [7:0]        scroll_step,
  input  logic [7:0]        scroll_top,
  input  logic [7:0]        scroll_bottom,
  input  logic              scroll_reset,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [CELL_W-1:0] ram_wdata,
  input  logic [CELL_W-1:0] ram_rdata
);

  localparam int COL_W = $clog2(COLS);
  localparam logic [7:0] LAST_ROW = 8'(LINES - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

  scroll_state_t state, state_n;
  scroll_job_t   job, job_n, sj;
  logic [7:0]       row, row_n;
  logic [COL_W-1:0] col, col_n;

  scroll_req_t in_req, pend_req;
  logic pend_valid, push, pop, flush;
  logic start, direct;

  logic [7:0] src_row, copy_end, clr_end;

  assign in_req = '{dir: scroll_dir,
                    step: scroll_step,
                    top: scroll_top,
                    bottom: scroll_bottom};

  scroll_req_queue u_queue (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .push       (push),
    .push_req   (in_req),
    .pop        (pop),
    .pend_valid (pend_valid),
    .pend_req   (pend_req),
    .overflow   (overflow)
  );

  function automatic logic [ADDR_W-1:0] addr_of(
    input logic [7:0]       r,
    input logic [COL_W-1:0] c
  );
    return ADDR_W'(r) * ADDR_W'(COLS) + ADDR_W'(c);
  endfunction

  assign src_row  = job.dir ? row - job.n : row + job.n;
  assign copy_end = job.dir ? job.top + job.n
                            : job.bot - job.n;
  assign clr_end  = job.dir ? job.top + job.n - 8'd1
                            : job.bot;

  assign busy = pend_valid ||
                (state == S_COPY_RD) ||
                (state == S_COPY_WR) ||
                (state == S_CLEAR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      job   <= '0;
      row   <= '0;
      col   <= '0;
    end else begin
      state <= state_n;
      job   <= job_n;
      row   <= row_n;
      col   <= col_n;
    end
  end

  always_comb begin
    state_n   = state;
    job_n     = job;
    row_n     = row;
    col_n     = col;
    pop       = 1'b0;
    flush     = 1'b0;
    start     = 1'b0;
    sj        = make_job(in_req, LAST_ROW);
    done      = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    direct    = (state == S_IDLE) && !pend_valid
              && scroll_valid;

    unique case (state)
      S_IDLE: begin
        if (pend_valid) begin
          start = 1'b1;
          pop   = 1'b1;
          sj    = make_job(pend_req, LAST_ROW);
        end else if (scroll_valid) begin
          start = 1'b1;
        end
      end
      S_COPY_RD: begin
        ram_addr = addr_of(src_row, col);
        state_n  = S_COPY_WR;
      end
      S_COPY_WR: begin
        ram_we    = 1'b1;
        ram_addr  = addr_of(row, col);
        ram_wdata = ram_rdata;
        state_n   = S_COPY_RD;
        col_n     = col + COL_W'(1);
        if (col == LAST_COL) begin
          col_n = '0;
          if (row == copy_end) begin
            state_n = S_CLEAR;
            row_n   = job.dir ? job.top
                    : job.bot - job.n + 8'd1;
          end else begin
            row_n = job.dir ? row - 8'd1
                            : row + 8'd1;
          end
        end
      end
      S_CLEAR: begin
        ram_we    = 1'b1;
        ram_addr  = addr_of(row, col);
        ram_wdata = BLANK_CELL;
        col_n     = col + COL_W'(1);
        if (col == LAST_COL) begin
          col_n = '0;
          row_n = row + 8'd1;
          if (row == clr_end) state_n = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_n = S_IDLE;
        if (pend_valid) begin
          start = 1'b1;
          pop   = 1'b1;
          sj    = make_job(pend_req, LAST_ROW);
        end
      end
      default: state_n = S_IDLE;
    endcase

    push = scroll_valid && !direct;

    if (start) begin
      job_n = sj;
      col_n = '0;
      if (sj.n == 8'd0) begin
        state_n = S_DONE;
      end else if (sj.n == sj.h) begin
        state_n = S_CLEAR;
        row_n   = sj.dir ? sj.top
                : sj.bot - sj.n + 8'd1;
      end else begin
        state_n = S_COPY_RD;
        row_n   = sj.dir ? sj.bot : sj.top;
      end
    end

    // Abort wins over everything, including a same-cycle request.
    if (scroll_reset) begin
      state_n = S_IDLE;
      pop     = 1'b0;
      push    = 1'b0;
      flush   = 1'b1;
    end
  end

endmodule

// File: tb/tb_text_scroll_engine.sv
// Directed bench for text_scroll_engine with a behavioural text RAM.
// Expected row maps are hand-derived per vector.
module tb_text_scroll_engine;

  localparam int COLS  = 80;
  localparam int LINES = 24;
  localparam logic [7:0] BL = 8'hFF;

  typedef logic [7:0] row_map_t [LINES];

  typedef struct {
    logic       dir;
    logic [7:0] step;
    logic [7:0] top;
    logic [7:0] bot;
    int         lat;
    int         writes;
    row_map_t   exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        scroll_valid, scroll_dir, scroll_reset;
  logic [7:0]  scroll_step, scroll_top, scroll_bottom;
  logic        busy, done, overflow, ram_we;
  logic [11:0] ram_addr;
  logic [31:0] ram_wdata, ram_rdata;

  logic [31:0] mem [0:4095];
  logic        do_init = 1'b0;
  int          wr_total = 0;
  int          done_total = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  vec_t        vecs [6];

  always #5 clk = ~clk;

  text_scroll_engine dut (
    .clk           (clk),
    .rst           (rst),
    .scroll_valid  (scroll_valid),
    .scroll_dir    (scroll_dir),
    .scroll_step   (scroll_step),
    .scroll_top    (scroll_top),
    .scroll_bottom (scroll_bottom),
    .scroll_reset  (scroll_reset),
    .busy          (busy),
    .done          (done),
    .overflow      (overflow),
    .ram_addr      (ram_addr),
    .ram_we        (ram_we),
    .ram_wdata     (ram_wdata),
    .ram_rdata     (ram_rdata)
  );

  function automatic logic [31:0] cell_val(int r, int c);
    return {1'b1, 15'd0, 8'(r), 8'(c)};
  endfunction

  always @(posedge clk) begin
    if (do_init) begin
      for (int r = 0; r < LINES; r++)
        for (int c = 0; c < COLS; c++)
          mem[r*COLS+c] = cell_val(r, c);
    end else if (ram_we) begin
      mem[ram_addr] = ram_wdata;
    end
    ram_rdata <= mem[ram_addr];
    if (ram_we) wr_total++;
    if (done) done_total++;
  end

  task automatic check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d",
               name, act, exp);
    end
  endtask

  task automatic init_ram;
    do_init = 1'b1;
    @(posedge clk); #1;
    do_init = 1'b0;
  endtask

  task automatic check_rows(string tag, row_map_t exp);
    for (int r = 0; r < LINES; r++) begin
      int bad = 0;
      for (int c = 0; c < COLS; c++) begin
        logic [31:0] e;
        e = (exp[r] == BL) ? 32'd0
          : cell_val(int'(exp[r]), c);
        if (mem[r*COLS+c] !== e) bad++;
      end
      check($sformatf("%s row%0d bad cells", tag, r),
            bad, 0);
    end
  endtask

  task automatic drive(logic d, logic [7:0] s,
                       logic [7:0] t, logic [7:0] b);
    scroll_valid  = 1'b1;
    scroll_dir    = d;
    scroll_step   = s;
    scroll_top    = t;
    scroll_bottom = b;
  endtask

  task automatic run_op(logic d, logic [7:0] s,
                        logic [7:0] t, logic [7:0] b,
                        output int lat);
    bit seen = 0;
    drive(d, s, t, b);
    lat = 0;
    for (int i = 0; i < 20000 && !seen; i++) begin
      @(posedge clk); #1;
      lat++;
      scroll_valid = 1'b0;
      if (done) seen = 1;
    end
    if (!seen) check("done timeout", 0, 1);
  endtask

  task automatic wait_cycles(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic row_map_t ident();
    row_map_t m;
    for (int r = 0; r < LINES; r++) m[r] = 8'(r);
    return m;
  endfunction

  initial begin
    int lat, w0, d0;
    row_map_t m;

    rst = 1'b1;
    scroll_valid = 1'b0;
    scroll_reset = 1'b0;
    scroll_dir = 1'b0;
    scroll_step = '0;
    scroll_top = '0;
    scroll_bottom = '0;
    #12;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset overflow", overflow, 0);
    check("reset we", ram_we, 0);
    check("reset addr", int'(ram_addr), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // vector table
    vecs[0] = '{0, 1, 0, 23, 3761, 1920, ident()};
    for (int r = 0; r < 23; r++) vecs[0].exp[r] = 8'(r + 1);
    vecs[0].exp[23] = BL;
    vecs[1] = '{1, 2, 5, 10, 801, 480, ident()};
    vecs[1].exp[5] = BL;
    vecs[1].exp[6] = BL;
    vecs[1].exp[7] = 5;
    vecs[1].exp[8] = 6;
    vecs[1].exp[9] = 7;
    vecs[1].exp[10] = 8;
    vecs[2] = '{0, 30, 2, 4, 241, 240, ident()};
    vecs[2].exp[2] = BL;
    vecs[2].exp[3] = BL;
    vecs[2].exp[4] = BL;
    vecs[3] = '{0, 1, 9, 3, 1, 0, ident()};
    vecs[4] = '{0, 3, 20, 40, 401, 320, ident()};
    vecs[4].exp[20] = 23;
    vecs[4].exp[21] = BL;
    vecs[4].exp[22] = BL;
    vecs[4].exp[23] = BL;
    vecs[5] = '{1, 1, 0, 0, 81, 80, ident()};
    vecs[5].exp[0] = BL;

    for (int k = 0; k < 6; k++) begin
      init_ram();
      w0 = wr_total;
      d0 = done_total;
      run_op(vecs[k].dir, vecs[k].step,
             vecs[k].top, vecs[k].bot, lat);
      check($sformatf("v%0d latency", k), lat, vecs[k].lat);
      check($sformatf("v%0d writes", k),
            wr_total - w0, vecs[k].writes);
      wait_cycles(2);
      check($sformatf("v%0d done pulses", k),
            done_total - d0, 1);
      check($sformatf("v%0d busy after", k), busy, 0);
      check_rows($sformatf("v%0d", k), vecs[k].exp);
    end

    // three back-to-back requests
    init_ram();
    d0 = done_total;
    drive(0, 1, 0, 23);
    @(posedge clk); #1;
    check("q busy next cycle", busy, 1);
    drive(1, 1, 0, 23);
    @(posedge clk); #1;
    drive(1, 1, 0, 23);
    @(posedge clk); #1;
    scroll_valid = 1'b0;
`ifdef SCROLL_MERGE_EN
    check("q overflow merged", overflow, 0);
`else
    check("q overflow dropped", overflow, 1);
`endif
    for (int i = 0; i < 20000 && done_total - d0 < 2; i++)
      @(posedge clk);
    wait_cycles(20);
    check("q done pulses", done_total - d0, 2);
    check("q busy end", busy, 0);
    m = ident();
    m[0] = BL;
`ifdef SCROLL_MERGE_EN
    m[1] = BL;
    for (int r = 2; r < LINES; r++) m[r] = 8'(r - 1);
`endif
    check_rows("q", m);

    // scroll_reset in the middle of a copy
    init_ram();
    d0 = done_total;
    drive(0, 1, 0, 23);
    @(posedge clk); #1;
    drive(1, 1, 0, 23);
    @(posedge clk); #1;
    drive(0, 1, 3, 23);
    @(posedge clk); #1;
    scroll_valid = 1'b0;
    check("sr overflow set", overflow, 1);
    wait_cycles(100);
    scroll_reset = 1'b1;
    @(posedge clk); #1;
    scroll_reset = 1'b0;
    check("sr busy", busy, 0);
    check("sr we", ram_we, 0);
    check("sr overflow clr", overflow, 0);
    check("sr done", done, 0);
    wait_cycles(30);
    check("sr no done", done_total - d0, 0);
    check("sr idle", busy, 0);
    w0 = wr_total;
    drive(0, 30, 2, 4);
    scroll_reset = 1'b1;
    @(posedge clk); #1;
    scroll_valid = 1'b0;
    scroll_reset = 1'b0;
    check("sr+valid busy", busy, 0);
    wait_cycles(10);
    check("sr+valid done", done_total - d0, 0);
    check("sr+valid writes", wr_total - w0, 0);

    // async rst in the middle of a clear
    init_ram();
    drive(0, 30, 2, 4);
    @(posedge clk); #1;
    scroll_valid = 1'b0;
    wait_cycles(50);
    check("ar we before", ram_we, 1);
    #3;
    rst = 1'b1;
    #1;
    check("ar busy", busy, 0);
    check("ar we", ram_we, 0);
    check("ar addr", int'(ram_addr), 0);
    check("ar wdata", int'(ram_wdata), 0);
    check("ar done", done, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    init_ram();
    w0 = wr_total;
    run_op(vecs[5].dir, vecs[5].step,
           vecs[5].top, vecs[5].bot, lat);
    check("ar post latency", lat, 81);
    check("ar post writes", wr_total - w0, 80);
    check_rows("ar post", vecs[5].exp);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
